// File: rtl/heading_stepper_if.sv
// Control pulses in, grid position / heading / motion vector out.
interface heading_stepper_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          start;
  logic          pause;
  logic          turn_right;
  logic          turn_left;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [1:0]    dir;
  logic [3:0]    motion;
  logic          step_pulse;
  logic          collide;

  modport master (
    output start, pause, turn_right, turn_left,
    input  pos_x, pos_y, dir, motion, step_pulse, collide
  );

  modport slave (
    input  start, pause, turn_right, turn_left,
    output pos_x, pos_y, dir, motion, step_pulse, collide
  );
endinterface

// File: rtl/heading_stepper.sv
// Four-way heading controller with step timer and wrapping (x,y) counters; pos/dir/step_pulse update 1 clk after timer wrap.
// Define WALL_COLLIDE_EN to stop at grid edges (collide + HALT) instead of wrapping.
module heading_stepper #(
  parameter int COLS     = 32,
  parameter int ROWS     = 24,
  parameter int STEP_DIV = 4,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0,
  parameter int INIT_DIR = 0,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int TW = $clog2(STEP_DIV)
) (
  input  logic             clk,
  input  logic             rstn,
  heading_stepper_if.slave hs
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_HALT} state_t;

  localparam logic [1:0]    D_E   = 2'd0;
  localparam logic [1:0]    D_S   = 2'd1;
  localparam logic [1:0]    D_W   = 2'd2;
  localparam logic [1:0]    D_N   = 2'd3;
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [TW-1:0] T_MAX = TW'(STEP_DIV - 1);

  state_t        state_q;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic [1:0]    dir_q, dir_d;
  logic [TW-1:0] timer_q;
  logic          pend_vld_q, pend_right_q;
  logic          step_pulse_q;
  logic          step_now;
  logic          turn_req;

  assign step_now = (state_q == S_RUN) && !hs.pause && (timer_q == T_MAX);
  // Opposite turns in the same cycle cancel out.
  assign turn_req = hs.turn_right ^ hs.turn_left;

  always_comb begin
    dir_d = dir_q;
    if (pend_vld_q) dir_d = pend_right_q ? dir_q + 2'd1 : dir_q - 2'd1;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (dir_d)
      D_E: pos_x_d = (pos_x_q == X_MAX) ? '0 : pos_x_q + 1'b1;
      D_W: pos_x_d = (pos_x_q == '0) ? X_MAX : pos_x_q - 1'b1;
      D_S: pos_y_d = (pos_y_q == Y_MAX) ? '0 : pos_y_q + 1'b1;
      default: pos_y_d = (pos_y_q == '0) ? Y_MAX : pos_y_q - 1'b1;
    endcase
  end

`ifdef WALL_COLLIDE_EN
  logic collide_q;
  logic wall_hit;
  assign wall_hit = ((dir_d == D_E) && (pos_x_q == X_MAX)) ||
                    ((dir_d == D_W) && (pos_x_q == '0))    ||
                    ((dir_d == D_S) && (pos_y_q == Y_MAX)) ||
                    ((dir_d == D_N) && (pos_y_q == '0));
  assign hs.collide = collide_q;
`else
  assign hs.collide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pos_x_q      <= XW'(INIT_X);
      pos_y_q      <= YW'(INIT_Y);
      dir_q        <= 2'(INIT_DIR);
      timer_q      <= '0;
      pend_vld_q   <= 1'b0;
      pend_right_q <= 1'b0;
      step_pulse_q <= 1'b0;
`ifdef WALL_COLLIDE_EN
      collide_q    <= 1'b0;
`endif
    end else begin
      step_pulse_q <= 1'b0;
      if (hs.start) begin
        state_q      <= S_RUN;
        pos_x_q      <= XW'(INIT_X);
        pos_y_q      <= YW'(INIT_Y);
        dir_q        <= 2'(INIT_DIR);
        timer_q      <= '0;
        pend_vld_q   <= 1'b0;
        pend_right_q <= 1'b0;
`ifdef WALL_COLLIDE_EN
        collide_q    <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_RUN: begin
            if (hs.pause) begin
              state_q <= S_PAUSE;
            end else if (step_now) begin
              timer_q      <= '0;
              dir_q        <= dir_d;
              step_pulse_q <= 1'b1;
`ifdef WALL_COLLIDE_EN
              if (wall_hit) begin
                collide_q <= 1'b1;
                state_q   <= S_HALT;
              end else begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
              end
`else
              pos_x_q <= pos_x_d;
              pos_y_q <= pos_y_d;
`endif
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_PAUSE: if (!hs.pause) state_q <= S_RUN;
          default: ;
        endcase

        // Step cycle consumes the pending turn; a turn in that same cycle waits for the next step.
        if (state_q == S_RUN || state_q == S_PAUSE) begin
          if (step_now) begin
            pend_vld_q   <= turn_req;
            pend_right_q <= hs.turn_right;
          end else if (!pend_vld_q && turn_req) begin
            pend_vld_q   <= 1'b1;
            pend_right_q <= hs.turn_right;
          end
        end
      end
    end
  end

  always_comb begin
    hs.motion = 4'b0000;
    if (state_q == S_RUN) begin
      case (dir_q)
        D_E:     hs.motion = 4'b0011;
        D_W:     hs.motion = 4'b0001;
        D_S:     hs.motion = 4'b1100;
        default: hs.motion = 4'b0100;
      endcase
    end
  end

  assign hs.pos_x      = pos_x_q;
  assign hs.pos_y      = pos_y_q;
  assign hs.dir        = dir_q;
  assign hs.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_heading_stepper.sv
// Directed bench for heading_stepper at COLS=8 ROWS=4 STEP_DIV=4, INIT (0,0) E; follows WALL_COLLIDE_EN.
module tb_heading_stepper;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  heading_stepper_if #(.XW(XW), .YW(YW)) hs ();

  heading_stepper #(
    .COLS(COLS), .ROWS(ROWS), .STEP_DIV(4),
    .INIT_X(0), .INIT_Y(0), .INIT_DIR(0)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .hs  (hs.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic r, input logic l, input logic s);
    hs.turn_right = r;
    hs.turn_left  = l;
    hs.start      = s;
    cyc(1);
    hs.turn_right = 1'b0;
    hs.turn_left  = 1'b0;
    hs.start      = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(hs.pos_x), x);
    chk({tag, "_y"}, int'(hs.pos_y), y);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn          = 1'b0;
    hs.start      = 1'b0;
    hs.pause      = 1'b0;
    hs.turn_right = 1'b0;
    hs.turn_left  = 1'b0;
    cyc(2);
    chk_pos("rst_pos", 0, 0);
    chk("rst_dir", int'(hs.dir), 0);
    chk("rst_motion", int'(hs.motion), 0);
    chk("rst_step", int'(hs.step_pulse), 0);
    chk("rst_collide", int'(hs.collide), 0);
    rstn = 1'b1;
    cyc(1);

    // Turns are ignored before the first start.
    pulse(1'b1, 1'b0, 1'b0);
    cyc(4);
    chk("idle_dir", int'(hs.dir), 0);
    chk("idle_motion", int'(hs.motion), 0);
    chk("idle_pos_x", int'(hs.pos_x), 0);

    pulse(1'b0, 1'b0, 1'b1);
    chk_pos("start_pos", 0, 0);
    chk("start_motion", int'(hs.motion), 4'b0011);
    for (int k = 1; k <= 7; k++) begin
      cyc(3);
      chk("run_nostep", int'(hs.step_pulse), 0);
      cyc(1);
      chk("run_step", int'(hs.step_pulse), 1);
      chk("run_pos_x", int'(hs.pos_x), k);
    end

    cyc(4);
    chk("edge_x_step", int'(hs.step_pulse), 1);
`ifdef WALL_COLLIDE_EN
    chk_pos("edge_x_hold", 7, 0);
    chk("edge_x_collide", int'(hs.collide), 1);
    chk("edge_x_motion", int'(hs.motion), 0);
    cyc(4);
    chk("halt_nostep", int'(hs.step_pulse), 0);
    chk("halt_pos_x", int'(hs.pos_x), 7);
`else
    chk_pos("edge_x_wrap", 0, 0);
    chk("edge_x_collide", int'(hs.collide), 0);
`endif
    pulse(1'b0, 1'b0, 1'b1);
    chk_pos("restart_pos", 0, 0);
    chk("restart_collide", int'(hs.collide), 0);
    chk("restart_motion", int'(hs.motion), 4'b0011);

    // Right turn mid-interval at (2,0): next step heads south.
    cyc(8);
    chk_pos("pre_turn", 2, 0);
    cyc(1);
    pulse(1'b1, 1'b0, 1'b0);
    cyc(1);
    chk("turn_not_yet", int'(hs.dir), 0);
    cyc(1);
    chk("turn_dir", int'(hs.dir), 1);
    chk_pos("turn_pos", 2, 1);
    chk("turn_motion", int'(hs.motion), 4'b1100);

    // Left turn on the step cycle itself is deferred one interval.
    cyc(3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("late_turn_dir", int'(hs.dir), 1);
    chk_pos("late_turn_pos", 2, 2);
    cyc(4);
    chk("late_turn_applied", int'(hs.dir), 0);
    chk_pos("late_turn_pos2", 3, 2);

    // Two lefts in one interval count once.
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    cyc(2);
    chk("dbl_left_dir", int'(hs.dir), 3);
    chk_pos("dbl_left_pos", 3, 1);
    chk("dbl_left_motion", int'(hs.motion), 4'b0100);

    pulse(1'b1, 1'b1, 1'b0);
    cyc(3);
    chk("cancel_dir", int'(hs.dir), 3);
    chk_pos("cancel_pos", 3, 0);

    // Pause with timer=2 for 10 clk.
    cyc(2);
    hs.pause = 1'b1;
    cyc(10);
    chk_pos("pause_pos", 3, 0);
    chk("pause_motion", int'(hs.motion), 0);
    chk("pause_step", int'(hs.step_pulse), 0);
    hs.pause = 1'b0;
    cyc(1);
    chk("resume_motion", int'(hs.motion), 4'b0100);
    cyc(1);
    chk("resume_nostep", int'(hs.step_pulse), 0);
    cyc(1);
    chk("resume_step", int'(hs.step_pulse), 1);
`ifdef WALL_COLLIDE_EN
    chk_pos("edge_y_hold", 3, 0);
    chk("edge_y_collide", int'(hs.collide), 1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("edge_y_restart", int'(hs.collide), 0);
    cyc(4);
    chk_pos("edge_y_run", 1, 0);
`else
    chk_pos("edge_y_wrap", 3, 3);
`endif

    // Asynchronous reset mid-operation.
    cyc(2);
    #2 rstn = 1'b0;
    #1;
    chk_pos("arst_pos", 0, 0);
    chk("arst_dir", int'(hs.dir), 0);
    chk("arst_motion", int'(hs.motion), 0);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
